// File: rtl/fetch_unit_pkg.sv
// Shared RV32I opcode encodings and fetch-side constants.
// Opcodes are instr[6:2]; bits [1:0] are always 2'b11 for 32-bit encodings.
package fetch_unit_pkg;

    typedef enum logic [4:0] {
        OPCODE_LOAD   = 5'b00000,
        OPCODE_FENCE  = 5'b00011,
        OPCODE_ARITHI = 5'b00100,
        OPCODE_ARITH  = 5'b01100,
        OPCODE_JALR   = 5'b11001,
        OPCODE_JAL    = 5'b11011,
        OPCODE_SYSTEM = 5'b11100
    } opcode_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_halt_op(input logic [4:0] op);
        return (op == OPCODE_SYSTEM) || (op == OPCODE_FENCE);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO for fetched {pc, instr} entries; head is read straight from
// the storage flops, so dout never depends combinationally on din.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch front end: PC register, imem addressing, and a small
// fetch queue toward decode with redirect flush and halt on SYSTEM/FENCE.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int               IMEM_AW     = 6,
    parameter int               FQ_DEPTH    = 4,
    parameter int               HALT_ON_SYS = 1,
    localparam int              CW          = $clog2(FQ_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               resume,
    input  logic               dec_ready,
    output logic               dec_valid,
    output logic [31:0]        dec_instr,
    output logic [XLEN-1:0]    dec_pc,
    output logic [XLEN-1:0]    dec_pc_plus4,
    output logic               halted,
    output logic [CW-1:0]      fq_count
);

    localparam int EW = XLEN + 32;

    logic [XLEN-1:0] fpc;
    logic            push;
    logic            pop;
    logic            full;
    logic [EW-1:0]   head;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    assign imem_addr = fpc[IMEM_AW+1:2];
    assign full      = (fq_count == CW'(FQ_DEPTH));
    assign dec_valid = (fq_count != '0);

    // Redirect squashes both ends of the queue for the cycle.
    assign pop  = dec_valid && dec_ready && !redirect_valid;
    assign push = !redirect_valid && !halted && (!full || pop);

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({fpc, imem_rdata}),
        .dout  (head),
        .count (fq_count)
    );

    assign head_pc    = head[EW-1:32];
    assign head_instr = head[31:0];

    assign dec_instr    = dec_valid ? head_instr : NOP_INSTR;
    assign dec_pc       = dec_valid ? head_pc : '0;
    assign dec_pc_plus4 = dec_valid ? head_pc + XLEN'(4) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc    <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            fpc    <= redirect_pc & ~XLEN'(3);
            halted <= 1'b0;
        end else begin
            if (push) fpc <= fpc + XLEN'(4);
            // A push implies !halted, so resume and halt-entry never collide.
            if (push && (HALT_ON_SYS != 0) && is_halt_op(imem_rdata[6:2]))
                halted <= 1'b1;
            else if (resume)
                halted <= 1'b0;
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation (pipelined) RV32I datapath. Owns the PC register, drives the instruction memory address and buffers fetched {pc, instruction} pairs in a small FIFO toward decode. Supports decode back-pressure, redirects from branch/JAL/JALR resolution, and a halt on SYSTEM/FENCE opcodes, released by an explicit resume. The single-cycle design instead freezes the PC in place.

Parameters:
XLEN, 32, PC and address width.
RESET_PC, 32'h0000_0000, PC value loaded at reset.
IMEM_AW, 6, instruction-memory word-address width.
FQ_DEPTH, 4, fetch-queue entries; power of two, >= 2.
HALT_ON_SYS, 1, 1 = stop fetching after pushing a SYSTEM/FENCE instruction.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
imem_addr  out  IMEM_AW  word address = fpc[IMEM_AW+1:2].
imem_rdata  in  32  combinational instruction read of imem_addr, same cycle.
redirect_valid  in  1  taken branch/jump resolved; flush and refetch.
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0).
resume  in  1  one-cycle pulse that clears halted.
dec_ready  in  1  decode accepts head entry this cycle.
dec_valid  out  1  queue non-empty.
dec_instr  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
dec_pc  out  XLEN  head PC; 0 when empty.
dec_pc_plus4  out  XLEN  dec_pc + 4 (JAL/JALR link value); 0 when empty.
halted  out  1  fetch stopped on SYSTEM/FENCE.
fq_count  out  $clog2(FQ_DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, async): fpc=RESET_PC, queue empty, count=0, halted=0. Outputs: dec_valid=0, dec_instr=NOP, dec_pc=0, dec_pc_plus4=0, fq_count=0.
- pop = dec_valid & dec_ready.
- push = !redirect_valid & !halted & (count<FQ_DEPTH | pop).
  - A full queue with a simultaneous pop still accepts a push.
- On push: enqueue {fpc, imem_rdata}, then fpc <= fpc+4, wrapping modulo 2^XLEN.
- Latency: the instruction at fpc appears at the decode outputs the cycle after its push (registered FIFO). After reset release, first dec_valid is at cycle 1, with dec_pc=RESET_PC.
- Decode outputs come from the registered head entry; no combinational path from imem_rdata to dec_*.
- Redirect has priority over everything:
  - queue cleared; count=0 next cycle.
  - fpc <= {redirect_pc[XLEN-1:2],2'b00}.
  - halted cleared; no push or pop that cycle.
  - dec_ready is ignored in that cycle.
- Halt: if HALT_ON_SYS=1 and a pushed instruction has opcode[6:2] = 5'b11100 or 5'b00011:
  - the instruction is enqueued normally and fpc advances by 4.
  - halted=1 from the next cycle; no further pushes.
  - pops continue, so the queue drains.
- resume while halted: halted=0 next cycle; fetch continues at the current fpc.
  - resume while not halted: no effect.
  - resume together with redirect_valid: redirect wins, target fpc, halted=0.
- Count update: push without pop +1; pop without push -1; both, unchanged.
- Empty queue: pop is impossible and dec_* show the empty values above.
- Full queue without pop: fpc holds and imem_addr is stable.
- FIFO pointers are log2(FQ_DEPTH) bits and wrap naturally; full/empty are derived from count.
- Asserting reset mid-stream discards all entries immediately (async) and clears halted.

Decomposition:
- Shared defines:
  - OPCODE_SYSTEM (5'b11100), OPCODE_FENCE (5'b00011), NOP_INSTR (32'h0000_0013).
  - These sit next to the existing OPCODE_JAL/JALR/Load/Arith entries.
- One sub-module, fetch_queue:
  - synchronous FIFO, parameters WIDTH and DEPTH.
  - ports: push, pop, flush, din, dout, count; async active-low reset.
  - fetch_unit instantiates it with WIDTH = XLEN+32.

Test Plan:
1. Reset release, dec_ready=1, imem returns addi words -> dec_pc sequence 0,4,8,12 on consecutive cycles from cycle 1; fq_count stays 1.
2. dec_ready=0 for 10 cycles -> fq_count reaches 4 (FQ_DEPTH) and holds; imem_addr frozen at 4 (fpc=16). Then dec_ready=1 -> in-order drain of pcs 0,4,8,12 with no gaps or duplicates.
3. Queue holding pcs 8,12,16 plus redirect_valid=1, redirect_pc=32'h0000_0042 -> next cycle fq_count=0, dec_valid=0, dec_instr=NOP. Following cycle dec_pc=32'h40.
4. imem returns 32'h0000_0073 (ECALL) at pc 20 -> entry pc 20 delivered, halted=1, no pc 24 entry. resume pulse -> next entry dec_pc=24.
5. Full queue with dec_ready=1 held -> push and pop each cycle; fq_count constant at 4; throughput of one instruction per cycle.
6. RESET_PC=32'hFFFF_FFF8, dec_ready=1 -> dec_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap). Asserting rst mid-run -> all outputs return to reset values with no clock edge required.
